// File: rtl/simd_operand_fetch_ctrl.sv
// rtl/simd_operand_fetch_ctrl.sv - serialises up to three VGPR operand reads per SIMD instruction
module simd_operand_fetch_ctrl #(
    parameter int DATA_W = 2048,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_issue_valid,
    output logic              out_issue_ready,
    input  logic [5:0]        in_wfid,
    input  logic [31:0]       in_opcode,
    input  logic              in_vgpr_source1_rd_en,
    input  logic              in_vgpr_source2_rd_en,
    input  logic              in_vgpr_source3_rd_en,
    input  logic [ADDR_W-1:0] in_source1_addr,
    input  logic [ADDR_W-1:0] in_source2_addr,
    input  logic [ADDR_W-1:0] in_source3_addr,
    output logic              out_vgpr_rd_req,
    output logic [ADDR_W-1:0] out_vgpr_rd_addr,
    input  logic              in_vgpr_rd_gnt,
    input  logic [DATA_W-1:0] in_vgpr_rd_data,
    output logic              out_alu_valid,
    input  logic              in_alu_ready,
    output logic [5:0]        out_wfid,
    output logic [31:0]       out_opcode,
    output logic [DATA_W-1:0] out_source1_data,
    output logic [DATA_W-1:0] out_source2_data,
    output logic [DATA_W-1:0] out_source3_data,
    output logic [15:0]       out_stall_cycles
);

    typedef enum logic [1:0] {IDLE, REQ, CAPTURE, ISSUE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [5:0]        wfid_q, wfid_d;
    logic [31:0]       opcode_q, opcode_d;
    logic [2:0]        en_q, en_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d, addr3_q, addr3_d;
    logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d, src3_q, src3_d;
    logic [15:0]       stall_q, stall_d;

    // Lowest enabled source strictly above cur; 0 means no source left to read.
    function automatic logic [1:0] next_src(input logic [2:0] en, input logic [1:0] cur);
        next_src = 2'd0;
        if (cur < 2'd1 && en[0]) begin
            next_src = 2'd1;
        end else if (cur < 2'd2 && en[1]) begin
            next_src = 2'd2;
        end else if (cur < 2'd3 && en[2]) begin
            next_src = 2'd3;
        end
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            wfid_q   <= '0;
            opcode_q <= '0;
            en_q     <= '0;
            addr1_q  <= '0;
            addr2_q  <= '0;
            addr3_q  <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            src3_q   <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wfid_q   <= wfid_d;
            opcode_q <= opcode_d;
            en_q     <= en_d;
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
            addr3_q  <= addr3_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            src3_q   <= src3_d;
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        wfid_d           = wfid_q;
        opcode_d         = opcode_q;
        en_d             = en_q;
        addr1_d          = addr1_q;
        addr2_d          = addr2_q;
        addr3_d          = addr3_q;
        src1_d           = src1_q;
        src2_d           = src2_q;
        src3_d           = src3_q;
        stall_d          = stall_q;
        out_issue_ready  = 1'b0;
        out_vgpr_rd_req  = 1'b0;
        out_vgpr_rd_addr = '0;
        out_alu_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                out_issue_ready = 1'b1;
                if (in_issue_valid) begin
                    wfid_d   = in_wfid;
                    opcode_d = in_opcode;
                    en_d     = {in_vgpr_source3_rd_en, in_vgpr_source2_rd_en, in_vgpr_source1_rd_en};
                    addr1_d  = in_source1_addr;
                    addr2_d  = in_source2_addr;
                    addr3_d  = in_source3_addr;
                    src1_d   = '0;
                    src2_d   = '0;
                    src3_d   = '0;
                    idx_d    = next_src(en_d, 2'd0);
                    state_d  = (idx_d == 2'd0) ? ISSUE : REQ;
                end
            end
            REQ: begin
                out_vgpr_rd_req = 1'b1;
                case (idx_q)
                    2'd1:    out_vgpr_rd_addr = addr1_q;
                    2'd2:    out_vgpr_rd_addr = addr2_q;
                    default: out_vgpr_rd_addr = addr3_q;
                endcase
                if (in_vgpr_rd_gnt) begin
                    state_d = CAPTURE;
                end else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
            end
            CAPTURE: begin
                // Read data arrives the cycle after the grant, i.e. in this state.
                case (idx_q)
                    2'd1:    src1_d = in_vgpr_rd_data;
                    2'd2:    src2_d = in_vgpr_rd_data;
                    default: src3_d = in_vgpr_rd_data;
                endcase
                idx_d   = next_src(en_q, idx_q);
                state_d = (idx_d == 2'd0) ? ISSUE : REQ;
            end
            ISSUE: begin
                out_alu_valid = 1'b1;
                if (in_alu_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_wfid         = wfid_q;
    assign out_opcode       = opcode_q;
    assign out_source1_data = src1_q;
    assign out_source2_data = src2_q;
    assign out_source3_data = src3_q;
    assign out_stall_cycles = stall_q;

endmodule

// File: tb/tb_simd_operand_fetch_ctrl.sv
// tb/tb_simd_operand_fetch_ctrl.sv - scoreboard bench for simd_operand_fetch_ctrl
module tb_simd_operand_fetch_ctrl;
    localparam int DW = 2048;
    localparam int AW = 10;

    typedef struct {
        logic [5:0]    wfid;
        logic [31:0]   opcode;
        logic [DW-1:0] s1;
        logic [DW-1:0] s2;
        logic [DW-1:0] s3;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          in_issue_valid;
    logic          out_issue_ready;
    logic [5:0]    in_wfid;
    logic [31:0]   in_opcode;
    logic          en1, en2, en3;
    logic [AW-1:0] a1, a2, a3;
    logic          out_vgpr_rd_req;
    logic [AW-1:0] out_vgpr_rd_addr;
    logic          in_vgpr_rd_gnt;
    logic [DW-1:0] in_vgpr_rd_data;
    logic          out_alu_valid;
    logic          in_alu_ready;
    logic [5:0]    out_wfid;
    logic [31:0]   out_opcode;
    logic [DW-1:0] out_source1_data, out_source2_data, out_source3_data;
    logic [15:0]   out_stall_cycles;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;

    simd_operand_fetch_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .in_issue_valid(in_issue_valid), .out_issue_ready(out_issue_ready),
        .in_wfid(in_wfid), .in_opcode(in_opcode),
        .in_vgpr_source1_rd_en(en1), .in_vgpr_source2_rd_en(en2), .in_vgpr_source3_rd_en(en3),
        .in_source1_addr(a1), .in_source2_addr(a2), .in_source3_addr(a3),
        .out_vgpr_rd_req(out_vgpr_rd_req), .out_vgpr_rd_addr(out_vgpr_rd_addr),
        .in_vgpr_rd_gnt(in_vgpr_rd_gnt), .in_vgpr_rd_data(in_vgpr_rd_data),
        .out_alu_valid(out_alu_valid), .in_alu_ready(in_alu_ready),
        .out_wfid(out_wfid), .out_opcode(out_opcode),
        .out_source1_data(out_source1_data), .out_source2_data(out_source2_data),
        .out_source3_data(out_source3_data), .out_stall_cycles(out_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DW-1:0] vgpr_word(input logic [AW-1:0] a);
        logic [31:0] w;
        if (a == 10'd10) return DW'(1);
        if (a == 10'd20) return DW'(2);
        if (a == 10'd30) return DW'(3);
        w = {22'h2A5A5, a};
        return {(DW/32){w}};
    endfunction

    // Advance one cycle; model the VGPR port returning data one cycle after a grant.
    task automatic step();
        logic          will;
        logic [AW-1:0] ga;
        will = out_vgpr_rd_req && in_vgpr_rd_gnt;
        ga   = out_vgpr_rd_addr;
        @(posedge clk);
        @(negedge clk);
        in_vgpr_rd_data = will ? vgpr_word(ga) : {(DW/32){32'hBAD00BAD}};
    endtask

    task automatic send(input logic [5:0] w, input logic [31:0] op, input logic [2:0] en,
                        input logic [AW-1:0] x1, input logic [AW-1:0] x2, input logic [AW-1:0] x3);
        exp_t e;
        in_issue_valid = 1'b1;
        in_wfid = w;
        in_opcode = op;
        {en3, en2, en1} = en;
        a1 = x1;
        a2 = x2;
        a3 = x3;
        e.wfid = w;
        e.opcode = op;
        e.s1 = en[0] ? vgpr_word(x1) : '0;
        e.s2 = en[1] ? vgpr_word(x2) : '0;
        e.s3 = en[2] ? vgpr_word(x3) : '0;
        sb.push_back(e);
        step();
        in_issue_valid = 1'b0;
        in_wfid = ~w;
        in_opcode = ~op;
        {en3, en2, en1} = ~en;
        a1 = ~x1;
        a2 = ~x2;
        a3 = ~x3;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_issue_valid = 1'b0;
        in_wfid = '0;
        in_opcode = '0;
        {en3, en2, en1} = 3'b000;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        in_vgpr_rd_gnt = 1'b0;
        in_vgpr_rd_data = '0;
        in_alu_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({out_issue_ready, out_vgpr_rd_req, out_vgpr_rd_addr, out_alu_valid} !== {1'b1, 1'b0, 10'd0, 1'b0})
            $display("FAIL reset_ctrl: got rdy=%b req=%b addr=%0d val=%b want 1 0 0 0",
                     out_issue_ready, out_vgpr_rd_req, out_vgpr_rd_addr, out_alu_valid);
        else passed++;
        total++;
        if ({out_wfid, out_opcode, out_stall_cycles} !== 54'd0)
            $display("FAIL reset_fields: got wfid=%h op=%h stall=%0d want 0", out_wfid, out_opcode, out_stall_cycles);
        else passed++;
        total++;
        if ((out_source1_data | out_source2_data | out_source3_data) !== '0)
            $display("FAIL reset_operands: got nonzero operand lo=%h want 0", out_source1_data[31:0]);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_three_sources();
        exp_t          e;
        logic          exp_req;
        logic [AW-1:0] exp_addr;
        in_vgpr_rd_gnt = 1'b1;
        in_alu_ready = 1'b1;
        total++;
        if (out_issue_ready !== 1'b1) $display("FAIL three_ready: got %b want 1", out_issue_ready);
        else passed++;
        send(6'h11, 32'hCAFE0001, 3'b111, 10'd10, 10'd20, 10'd30);
        for (int off = 1; off <= 7; off++) begin
            exp_req  = (off == 1) || (off == 3) || (off == 5);
            exp_addr = (off == 1) ? 10'd10 : (off == 3) ? 10'd20 : 10'd30;
            total++;
            if ({out_vgpr_rd_req, out_alu_valid} !== {exp_req, off == 7} || (exp_req && out_vgpr_rd_addr !== exp_addr))
                $display("FAIL three_t%0d: got req=%b addr=%0d val=%b want req=%b addr=%0d val=%b",
                         off, out_vgpr_rd_req, out_vgpr_rd_addr, out_alu_valid, exp_req, exp_addr, off == 7);
            else passed++;
            if (off == 7) begin
                total++;
                if (sb.size() == 0) $display("FAIL three_sb: got empty scoreboard want 1 entry");
                else begin
                    e = sb.pop_front();
                    if ({out_wfid, out_opcode, out_source1_data, out_source2_data, out_source3_data} !== {e.wfid, e.opcode, e.s1, e.s2, e.s3})
                        $display("FAIL three_bundle: got wfid=%h op=%h s=%h/%h/%h want wfid=%h op=%h s=%h/%h/%h",
                                 out_wfid, out_opcode, out_source1_data[31:0], out_source2_data[31:0], out_source3_data[31:0],
                                 e.wfid, e.opcode, e.s1[31:0], e.s2[31:0], e.s3[31:0]);
                    else passed++;
                end
            end
            step();
        end
        total++;
        if ({out_issue_ready, out_alu_valid} !== 2'b10)
            $display("FAIL three_after_accept: got rdy=%b val=%b want 1 0", out_issue_ready, out_alu_valid);
        else passed++;
    endtask

    task automatic test_single_src2();
        exp_t e;
        logic exp_req;
        send(6'h22, 32'h00000B0B, 3'b010, 10'd11, 10'd5, 10'd13);
        for (int off = 1; off <= 3; off++) begin
            exp_req = (off == 1);
            total++;
            if ({out_vgpr_rd_req, out_alu_valid} !== {exp_req, off == 3} || (exp_req && out_vgpr_rd_addr !== 10'd5))
                $display("FAIL src2_t%0d: got req=%b addr=%0d val=%b want req=%b addr=5 val=%b",
                         off, out_vgpr_rd_req, out_vgpr_rd_addr, out_alu_valid, exp_req, off == 3);
            else passed++;
            if (off == 3) begin
                total++;
                if (sb.size() == 0) $display("FAIL src2_sb: got empty scoreboard want 1 entry");
                else begin
                    e = sb.pop_front();
                    if ({out_wfid, out_opcode, out_source1_data, out_source2_data, out_source3_data} !== {e.wfid, e.opcode, e.s1, e.s2, e.s3})
                        $display("FAIL src2_bundle: got wfid=%h op=%h s=%h/%h/%h want wfid=%h op=%h s=%h/%h/%h",
                                 out_wfid, out_opcode, out_source1_data[31:0], out_source2_data[31:0], out_source3_data[31:0],
                                 e.wfid, e.opcode, e.s1[31:0], e.s2[31:0], e.s3[31:0]);
                    else passed++;
                end
            end
            step();
        end
    endtask

    task automatic test_no_sources();
        exp_t e;
        send(6'h33, 32'h12345678, 3'b000, 10'd1, 10'd2, 10'd3);
        total++;
        if ({out_vgpr_rd_req, out_alu_valid} !== 2'b01)
            $display("FAIL nosrc_t1: got req=%b val=%b want 0 1", out_vgpr_rd_req, out_alu_valid);
        else passed++;
        total++;
        if (sb.size() == 0) $display("FAIL nosrc_sb: got empty scoreboard want 1 entry");
        else begin
            e = sb.pop_front();
            if ({out_wfid, out_opcode, out_source1_data, out_source2_data, out_source3_data} !== {e.wfid, e.opcode, e.s1, e.s2, e.s3})
                $display("FAIL nosrc_bundle: got wfid=%h op=%h s=%h/%h/%h want wfid=%h op=%h s=%h/%h/%h",
                         out_wfid, out_opcode, out_source1_data[31:0], out_source2_data[31:0], out_source3_data[31:0],
                         e.wfid, e.opcode, e.s1[31:0], e.s2[31:0], e.s3[31:0]);
            else passed++;
        end
        step();
    endtask

    task automatic test_stall();
        exp_t e;
        logic exp_req;
        in_vgpr_rd_gnt = 1'b0;
        send(6'h07, 32'h0000DEAD, 3'b001, 10'd7, 10'd8, 10'd9);
        for (int off = 1; off <= 7; off++) begin
            exp_req = (off <= 5);
            total++;
            if ({out_vgpr_rd_req, out_alu_valid} !== {exp_req, off == 7} || (exp_req && out_vgpr_rd_addr !== 10'd7))
                $display("FAIL stall_t%0d: got req=%b addr=%0d val=%b want req=%b addr=7 val=%b",
                         off, out_vgpr_rd_req, out_vgpr_rd_addr, out_alu_valid, exp_req, off == 7);
            else passed++;
            if (off == 3 || off == 7) begin
                total++;
                if (out_stall_cycles !== ((off == 3) ? 16'd2 : 16'd4))
                    $display("FAIL stall_count_t%0d: got %0d want %0d", off, out_stall_cycles, (off == 3) ? 2 : 4);
                else passed++;
            end
            if (off == 7) begin
                total++;
                if (sb.size() == 0) $display("FAIL stall_sb: got empty scoreboard want 1 entry");
                else begin
                    e = sb.pop_front();
                    if ({out_wfid, out_opcode, out_source1_data, out_source2_data, out_source3_data} !== {e.wfid, e.opcode, e.s1, e.s2, e.s3})
                        $display("FAIL stall_bundle: got wfid=%h op=%h s=%h/%h/%h want wfid=%h op=%h s=%h/%h/%h",
                                 out_wfid, out_opcode, out_source1_data[31:0], out_source2_data[31:0], out_source3_data[31:0],
                                 e.wfid, e.opcode, e.s1[31:0], e.s2[31:0], e.s3[31:0]);
                    else passed++;
                end
            end
            in_vgpr_rd_gnt = (off >= 5);
            step();
        end
    endtask

    task automatic test_alu_backpressure();
        exp_t e;
        in_vgpr_rd_gnt = 1'b1;
        in_alu_ready = 1'b0;
        send(6'h2B, 32'hA5A50F0F, 3'b100, 10'd1, 10'd2, 10'd9);
        for (int off = 1; off <= 8; off++) begin
            total++;
            if ({out_vgpr_rd_req, out_alu_valid} !== {off == 1, off >= 3} || (off == 1 && out_vgpr_rd_addr !== 10'd9))
                $display("FAIL bp_t%0d: got req=%b addr=%0d val=%b want req=%b addr=9 val=%b",
                         off, out_vgpr_rd_req, out_vgpr_rd_addr, out_alu_valid, off == 1, off >= 3);
            else passed++;
            if (off >= 3 && off <= 7) begin
                total++;
                if (sb.size() == 0) $display("FAIL bp_hold_sb: got empty scoreboard want 1 entry");
                else if (out_issue_ready !== 1'b0 ||
                         {out_wfid, out_opcode, out_source1_data, out_source2_data, out_source3_data} !== {sb[0].wfid, sb[0].opcode, sb[0].s1, sb[0].s2, sb[0].s3})
                    $display("FAIL bp_hold_t%0d: got rdy=%b wfid=%h op=%h s3=%h want rdy=0 wfid=%h op=%h s3=%h",
                             off, out_issue_ready, out_wfid, out_opcode, out_source3_data[31:0],
                             sb[0].wfid, sb[0].opcode, sb[0].s3[31:0]);
                else passed++;
                in_issue_valid = 1'b1;
                in_wfid = 6'h3F;
                {en3, en2, en1} = 3'b111;
            end
            if (off == 8) begin
                in_issue_valid = 1'b0;
                in_alu_ready = 1'b1;
                total++;
                if (sb.size() == 0) $display("FAIL bp_sb: got empty scoreboard want 1 entry");
                else begin
                    e = sb.pop_front();
                    if ({out_wfid, out_opcode, out_source1_data, out_source2_data, out_source3_data} !== {e.wfid, e.opcode, e.s1, e.s2, e.s3})
                        $display("FAIL bp_bundle: got wfid=%h op=%h s=%h/%h/%h want wfid=%h op=%h s=%h/%h/%h",
                                 out_wfid, out_opcode, out_source1_data[31:0], out_source2_data[31:0], out_source3_data[31:0],
                                 e.wfid, e.opcode, e.s1[31:0], e.s2[31:0], e.s3[31:0]);
                    else passed++;
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        total++;
        if ({out_issue_ready, out_alu_valid} !== 2'b10)
            $display("FAIL b2b_ready: got rdy=%b val=%b want 1 0", out_issue_ready, out_alu_valid);
        else passed++;
        send(6'h15, 32'h0BADF00D, 3'b000, 10'd0, 10'd0, 10'd0);
        total++;
        if (sb.size() == 0 || out_alu_valid !== 1'b1) $display("FAIL b2b_valid: got val=%b sb=%0d want val=1 sb=1", out_alu_valid, sb.size());
        else begin
            e = sb.pop_front();
            if ({out_wfid, out_opcode, out_source1_data, out_source2_data, out_source3_data} !== {e.wfid, e.opcode, e.s1, e.s2, e.s3})
                $display("FAIL b2b_bundle: got wfid=%h op=%h s=%h/%h/%h want wfid=%h op=%h s=%h/%h/%h",
                         out_wfid, out_opcode, out_source1_data[31:0], out_source2_data[31:0], out_source3_data[31:0],
                         e.wfid, e.opcode, e.s1[31:0], e.s2[31:0], e.s3[31:0]);
            else passed++;
        end
        step();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        in_vgpr_rd_gnt = 1'b1;
        in_alu_ready = 1'b1;
        send(6'h05, 32'h55550000, 3'b111, 10'd1, 10'd2, 10'd3);
        repeat (3) step();
        rst = 1'b0;
        #1;
        total++;
        if ({out_issue_ready, out_vgpr_rd_req, out_vgpr_rd_addr, out_alu_valid} !== {1'b1, 1'b0, 10'd0, 1'b0})
            $display("FAIL rstmid_ctrl: got rdy=%b req=%b addr=%0d val=%b want 1 0 0 0",
                     out_issue_ready, out_vgpr_rd_req, out_vgpr_rd_addr, out_alu_valid);
        else passed++;
        total++;
        if ({out_wfid, out_opcode, out_stall_cycles} !== 54'd0 || (out_source1_data | out_source2_data | out_source3_data) !== '0)
            $display("FAIL rstmid_data: got wfid=%h op=%h stall=%0d s1=%h want 0", out_wfid, out_opcode, out_stall_cycles, out_source1_data[31:0]);
        else passed++;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(6'h06, 32'h66660000, 3'b010, 10'd50, 10'd40, 10'd60);
        for (int off = 1; off <= 3; off++) begin
            total++;
            if ({out_vgpr_rd_req, out_alu_valid} !== {off == 1, off == 3} || (off == 1 && out_vgpr_rd_addr !== 10'd40))
                $display("FAIL rstmid_t%0d: got req=%b addr=%0d val=%b want req=%b addr=40 val=%b",
                         off, out_vgpr_rd_req, out_vgpr_rd_addr, out_alu_valid, off == 1, off == 3);
            else passed++;
            if (off == 3) begin
                total++;
                if (sb.size() == 0) $display("FAIL rstmid_sb: got empty scoreboard want 1 entry");
                else begin
                    e = sb.pop_front();
                    if ({out_wfid, out_opcode, out_source1_data, out_source2_data, out_source3_data, out_stall_cycles} !== {e.wfid, e.opcode, e.s1, e.s2, e.s3, 16'd0})
                        $display("FAIL rstmid_bundle: got wfid=%h op=%h s=%h/%h/%h stall=%0d want wfid=%h op=%h s=%h/%h/%h stall=0",
                                 out_wfid, out_opcode, out_source1_data[31:0], out_source2_data[31:0], out_source3_data[31:0], out_stall_cycles,
                                 e.wfid, e.opcode, e.s1[31:0], e.s2[31:0], e.s3[31:0]);
                    else passed++;
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_three_sources();
        test_single_src2();
        test_no_sources();
        test_stall();
        test_alu_backpressure();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (sb.size() != 0) $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
